// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one outstanding data-memory transaction, byte-lane store formatting, load alignment/extension.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of forcing them to natural alignment.
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        dm_req,
    output logic [3:0]  dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        st_done,
    output logic        misalign
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    function automatic logic [1:0] size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: size_of = SZ_B;
            3'b001, 3'b101: size_of = SZ_H;
            default:        size_of = SZ_W;
        endcase
    endfunction

    logic [1:0]  state;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;
    logic        accept_ok;

    logic [1:0]  size_q;
    logic [1:0]  off;
    logic [3:0]  strobe;
    logic [31:0] lane_data;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    assign size_q = size_of(funct3_q);

    // Misaligned H/W offsets collapse to natural alignment in the default build
    always_comb begin
        case (size_q)
            SZ_B:    off = addr_q[1:0];
            SZ_H:    off = {addr_q[1], 1'b0};
            default: off = 2'b00;
        endcase
    end

    always_comb begin
        case (size_q)
            SZ_B: begin
                strobe    = 4'b0001 << off;
                lane_data = {4{wdata_q[7:0]}};
            end
            SZ_H: begin
                strobe    = 4'b0011 << off;
                lane_data = {2{wdata_q[15:0]}};
            end
            default: begin
                strobe    = 4'b1111;
                lane_data = wdata_q;
            end
        endcase
    end

    always_comb begin
        shifted = dm_rdata >> {off, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic [1:0] req_size;
    logic       req_misaligned;
    logic       misalign_q;

    assign req_size       = size_of(req_funct3);
    assign req_misaligned = (req_size == SZ_H && req_addr[0]) ||
                            (req_size == SZ_W && req_addr[1:0] != 2'b00);
    assign accept_ok      = !req_misaligned;
    assign misalign       = misalign_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            misalign_q <= 1'b0;
        else
            misalign_q <= (state == IDLE) && req_valid && req_misaligned;
    end
`else
    assign accept_ok = 1'b1;
    assign misalign  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        is_store_q <= req_is_store;
                        funct3_q   <= req_funct3;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        rd_q       <= req_rd;
                        if (accept_ok)
                            state <= REQ;
                    end
                end
                REQ: begin
                    if (dm_gnt)
                        state <= is_store_q ? IDLE : WAIT;
                end
                WAIT: begin
                    if (dm_rvalid) begin
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= load_ext;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign dm_req    = (state == REQ);
    assign dm_addr   = dm_req ? {addr_q[31:2], 2'b00} : '0;
    assign dm_we     = (dm_req && is_store_q) ? strobe : 4'b0000;
    assign dm_wdata  = (dm_req && is_store_q) ? lane_data : '0;
    assign st_done   = dm_req && is_store_q && dm_gnt;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign wb_we     = wb_valid_q && (wb_rd_q != 5'd0);

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed cases plus randomized loads/stores against a byte-level reference model.
module tb_mem_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        st_done;
    logic        misalign;

    mem_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .st_done(st_done), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Access width in bytes as the ISA defines it; anything unlisted is a word
    function automatic int nbytes_of(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic int base_of(input logic [2:0] f3, input logic [31:0] addr);
        int n = nbytes_of(f3);
        return (int'(addr % 4) / n) * n;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int n = nbytes_of(f3);
        int o = base_of(f3, addr);
        longint unsigned val = 0;
        longint unsigned lim;
        logic [63:0] r64;
        for (int i = 0; i < n; i++)
            val += longint'((rdata >> (8 * (o + i))) & 32'hFF) << (8 * i);
        lim = 64'd1 << (8 * n);
        if ((f3 == 3'b000 || f3 == 3'b001) && val >= lim / 2)
            val = val + (64'd1 << 32) - lim;
        r64 = val;
        return r64[31:0];
    endfunction

    function automatic logic [3:0] ref_we(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] we = '0;
        int n = nbytes_of(f3);
        int o = base_of(f3, addr);
        for (int i = 0; i < n; i++) we[o + i] = 1'b1;
        return we;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wdata);
        logic [31:0] out = '0;
        int n = nbytes_of(f3);
        for (int i = 0; i < 4; i++) out[8 * i +: 8] = wdata[8 * (i % n) +: 8];
        return out;
    endfunction

    task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [31:0] rdata, input int g, input int r);
        check_eq("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wdata;
        req_rd       = rd;
        tick();
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_rd    = 5'($urandom);
        for (int k = 0; k <= g; k++) begin
            dm_gnt    = (k == g);
            dm_rvalid = (k < g) ? 1'($urandom % 2) : 1'b0;
            dm_rdata  = $urandom;
            #1;
            check_eq("req_dm_req", {31'd0, dm_req}, 32'd1);
            check_eq("req_ready_low", {31'd0, req_ready}, 32'd0);
            check_eq("req_addr", dm_addr, addr & ~32'd3);
            check_eq("req_we", {28'd0, dm_we}, st ? {28'd0, ref_we(f3, addr)} : 32'd0);
            if (st) check_eq("req_wdata", dm_wdata, ref_wdata(f3, wdata));
            check_eq("req_wb_valid", {31'd0, wb_valid}, 32'd0);
            check_eq("req_st_done", {31'd0, st_done}, {31'd0, (k == g) && st});
            tick();
        end
        dm_gnt    = 1'b0;
        dm_rvalid = 1'b0;
        if (st) begin
            #1;
            check_eq("st_back_idle", {31'd0, req_ready}, 32'd1);
            check_eq("st_no_wb", {31'd0, wb_valid}, 32'd0);
            check_eq("st_done_pulse", {31'd0, st_done}, 32'd0);
            return;
        end
        for (int k = 0; k <= r; k++) begin
            dm_rvalid = (k == r);
            dm_gnt    = 1'($urandom % 2);
            dm_rdata  = (k == r) ? rdata : $urandom;
            #1;
            check_eq("wait_dm_req", {31'd0, dm_req}, 32'd0);
            check_eq("wait_ready", {31'd0, req_ready}, 32'd0);
            check_eq("wait_st_done", {31'd0, st_done}, 32'd0);
            check_eq("wait_wb_valid", {31'd0, wb_valid}, 32'd0);
            tick();
        end
        dm_rvalid = 1'b0;
        dm_gnt    = 1'b0;
        dm_rdata  = $urandom;
        #1;
        check_eq("wb_valid", {31'd0, wb_valid}, 32'd1);
        check_eq("wb_rd", {27'd0, wb_rd}, {27'd0, rd});
        check_eq("wb_we", {31'd0, wb_we}, {31'd0, rd != 5'd0});
        check_eq("wb_data", wb_data, ref_load(f3, addr, rdata));
        check_eq("wb_ready", {31'd0, req_ready}, 32'd1);
        check_eq("wb_misalign", {31'd0, misalign}, 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        check_eq({tag, "_outs"}, {dm_req, dm_we, wb_valid, wb_we, st_done, misalign, wb_rd},
                 32'd0);
        check_eq({tag, "_addr"}, dm_addr, 32'd0);
        check_eq({tag, "_wdata"}, dm_wdata, 32'd0);
        check_eq({tag, "_wbdata"}, wb_data, 32'd0);
    endtask

    initial begin
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = 3'b000;
        req_addr     = '0;
        req_wdata    = '0;
        req_rd       = '0;
        dm_gnt       = 1'b0;
        dm_rvalid    = 1'b0;
        dm_rdata     = '0;
        #2;
        check_quiet("reset");
        tick();
        tick();
        rst = 1'b1;
        tick();

        do_op(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd0, 32'd0, 0, 0);
        do_op(1'b0, 3'b000, 32'h0000_2001, 32'd0, 5'd5, 32'h0000_8000, 0, 0);
        do_op(1'b0, 3'b100, 32'h0000_2001, 32'd0, 5'd5, 32'h0000_8000, 0, 0);
        do_op(1'b0, 3'b001, 32'h0000_2002, 32'd0, 5'd7, 32'h8001_0000, 3, 1);
        do_op(1'b0, 3'b010, 32'h0000_4000, 32'd0, 5'd0, 32'hDEAD_BEEF, 1, 2);
        do_op(1'b1, 3'b001, 32'h0000_5002, 32'h1234_5678, 5'd0, 32'd0, 2, 0);
        do_op(1'b1, 3'b010, 32'h0000_6000, 32'hCAFE_F00D, 5'd0, 32'd0, 0, 0);

`ifdef LSU_MISALIGN_TRAP_EN
        req_valid  = 1'b1;
        req_is_store = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_3002;
        req_rd     = 5'd3;
        tick();
        req_valid = 1'b0;
        #1;
        check_eq("mis_pulse", {31'd0, misalign}, 32'd1);
        check_eq("mis_no_req", {31'd0, dm_req}, 32'd0);
        tick();
        check_eq("mis_one_cycle", {31'd0, misalign}, 32'd0);
        check_eq("mis_no_req2", {31'd0, dm_req}, 32'd0);
        check_eq("mis_no_wb", {31'd0, wb_valid}, 32'd0);
`else
        do_op(1'b0, 3'b010, 32'h0000_3002, 32'd0, 5'd9, 32'h0102_0304, 0, 0);
        do_op(1'b1, 3'b001, 32'h0000_3003, 32'h0000_BEEF, 5'd0, 32'd0, 1, 0);
`endif

        // Reset while a load waits for data; the late response must vanish
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_funct3   = 3'b010;
        req_addr     = 32'h0000_7000;
        req_rd       = 5'd4;
        tick();
        req_valid = 1'b0;
        dm_gnt    = 1'b1;
        tick();
        dm_gnt = 1'b0;
        #1;
        check_eq("pre_rst_wait", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check_quiet("async_rst");
        tick();
        rst       = 1'b1;
        dm_rvalid = 1'b1;
        dm_rdata  = 32'h5555_AAAA;
        tick();
        dm_rvalid = 1'b0;
        check_quiet("post_rst");
        tick();
        check_eq("post_rst_wb", {31'd0, wb_valid}, 32'd0);

        for (int i = 0; i < 300; i++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            bit          st;
            st = 1'($urandom % 2);
            if (st) f3 = 3'($urandom_range(0, 2));
            else    f3 = 3'($urandom);
            a = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
            a = a & ~32'(nbytes_of(f3) - 1);
`endif
            do_op(st, f3, a, $urandom, 5'($urandom), $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3));
        end
        tick();
        check_eq("final_wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("final_ready", {31'd0, req_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
